// File: rtl/t07_spi_tft_writer_if.sv
// Write-request channel between the MMIO decoder's TFT window and the SPI TFT writer.
// The decoder drives the request; the writer answers with a stall flag.
interface t07_spi_tft_writer_if;
    logic        wi_in;
    logic [31:0] addr_in;
    logic [31:0] writeData_in;
    logic        ack_TFT;

    modport master (output wi_in, output addr_in, output writeData_in, input ack_TFT);
    modport slave  (input wi_in, input addr_in, input writeData_in, output ack_TFT);
endinterface

// File: rtl/t07_spi_tft_writer.sv
// SPI mode-0 master for the TFT: serialises 1, 2 or 4 bytes MSB first per decoder write,
// with D/C taken from addr[3:2] and a stall flag held while the bytes are going out.
module t07_spi_tft_writer #(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    t07_spi_tft_writer_if.slave   bus,
    output logic                  tft_sclk,
    output logic                  tft_mosi,
    output logic                  tft_cs_n,
    output logic                  tft_dc
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [31:0]      shreg;

    logic [1:0]  mode;
    logic [31:0] load_data;
    logic [4:0]  load_bits;
    logic        unused_addr;

    assign mode        = bus.addr_in[3:2];
    assign unused_addr = ^{bus.addr_in[31:4], bus.addr_in[1:0]};

    // Left-align the selected width so bit 31 is always the next bit on the wire.
    always_comb begin
        load_data = bus.writeData_in;
        load_bits = 5'd31;
        case (mode)
            2'b00, 2'b01: begin
                load_data = {bus.writeData_in[7:0], 24'h0};
                load_bits = 5'd7;
            end
            2'b10: begin
                load_data = {bus.writeData_in[15:0], 16'h0};
                load_bits = 5'd15;
            end
            default: begin
                load_data = bus.writeData_in;
                load_bits = 5'd31;
            end
        endcase
    end

    // NOTE: the stall must rise in the request cycle itself, so it is decoded from the
    // registered state plus wi_in rather than registered; DONE drops it to release the CPU.
    assign bus.ack_TFT = !rst && ((state == IDLE && bus.wi_in) || state == SETUP || state == SHIFT);

    // NOTE: all state and pin registers use non-blocking assignments so every branch
    // reads the pre-edge values of tft_sclk, shreg and the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tft_cs_n <= 1'b1;
            tft_sclk <= 1'b0;
            tft_mosi <= 1'b0;
            tft_dc   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wi_in) begin
                        state    <= SETUP;
                        tft_cs_n <= 1'b0;
                        tft_dc   <= (mode != 2'b00);
                        shreg    <= load_data;
                        tft_mosi <= load_data[31];
                        bit_cnt  <= load_bits;
                        div_cnt  <= '0;
                    end
                end
                SETUP: state <= SHIFT;
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!tft_sclk) begin
                            tft_sclk <= 1'b1;
                        end else begin
                            // End of a high phase: either finish or present the next bit.
                            tft_sclk <= 1'b0;
                            if (bit_cnt == 5'd0) begin
                                state    <= DONE;
                                tft_cs_n <= 1'b1;
                                tft_mosi <= 1'b0;
                            end else begin
                                bit_cnt  <= bit_cnt - 5'd1;
                                shreg    <= {shreg[30:0], 1'b0};
                                tft_mosi <= shreg[30];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_t07_spi_tft_writer.sv
// Self-checking bench for t07_spi_tft_writer: directed scenarios plus randomized transfers
// compared against a transfer-level model (byte stream, D/C, stall length, CS framing).
module tb_t07_spi_tft_writer;
    localparam int CLK_DIV = 2;

    logic clk = 1'b0;
    logic rst;
    logic tft_sclk, tft_mosi, tft_cs_n, tft_dc;

    int checks      = 0;
    int failures    = 0;
    int cs_high_run = 0;

    t07_spi_tft_writer_if bus ();

    t07_spi_tft_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .tft_sclk (tft_sclk),
        .tft_mosi (tft_mosi),
        .tft_cs_n (tft_cs_n),
        .tft_dc   (tft_dc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mode_addr(input logic [1:0] mode);
        return 32'd1024 + {28'h0, mode, 2'b00};
    endfunction

    function automatic int mode_bytes(input logic [1:0] mode);
        return (mode == 2'b11) ? 4 : (mode == 2'b10) ? 2 : 1;
    endfunction

    // One full transfer from the request cycle T0 to the DONE cycle (returns at DONE's sample).
    // chain: keep wi high with the next request from T1 on; hold: keep this request driven
    // until cycle T<hold>; scramble: random wi/addr/data while busy; chk_gap: expect CS high 2 cycles.
    task automatic xfer(input logic [1:0] mode, input logic [31:0] data, input bit chain,
                        input logic [1:0] nmode, input logic [31:0] ndata,
                        input int hold, input bit scramble, input bit chk_gap);
        int          n       = mode_bytes(mode);
        int          exp_ack = 2 + 16 * n * CLK_DIV;
        logic [31:0] mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        logic        exp_dc  = (mode != 2'b00);
        int          ack_cnt = 0;
        int          cs_low  = 0;
        int          nbits   = 0;
        logic [31:0] got     = '0;
        bit          dc_ok   = 1'b1;
        bit          sclk_ok = 1'b1;
        bit          done    = 1'b0;
        bit          gap_done = 1'b0;
        logic        prev_sclk;

        @(posedge clk); #1;
        bus.wi_in        = 1'b1;
        bus.addr_in      = mode_addr(mode);
        bus.writeData_in = data;
        @(negedge clk);
        check("t0_ack", {31'h0, bus.ack_TFT}, 32'd1);
        check("t0_cs_n", {31'h0, tft_cs_n}, 32'd1);
        ack_cnt   = 1;
        prev_sclk = tft_sclk;
        if (tft_cs_n) cs_high_run++;

        for (int c = 1; c < 4000 && !done; c++) begin
            @(posedge clk); #1;
            if (chain) begin
                bus.wi_in        = 1'b1;
                bus.addr_in      = mode_addr(nmode);
                bus.writeData_in = ndata;
            end else if (c >= hold) begin
                bus.wi_in        = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.addr_in      = $urandom;
                bus.writeData_in = $urandom;
            end
            @(negedge clk);
            if (tft_cs_n) begin
                cs_high_run++;
            end else begin
                if (chk_gap && !gap_done) begin
                    check("cs_gap", cs_high_run, 32'd2);
                    gap_done = 1'b1;
                end
                cs_high_run = 0;
            end
            if (bus.ack_TFT) begin
                ack_cnt++;
                if (!tft_cs_n) cs_low++;
                if (!tft_cs_n && tft_dc !== exp_dc) dc_ok = 1'b0;
                if (tft_sclk && tft_cs_n) sclk_ok = 1'b0;
                if (tft_sclk && !prev_sclk) begin
                    got = {got[30:0], tft_mosi};
                    nbits++;
                end
            end else begin
                done = 1'b1;
            end
            prev_sclk = tft_sclk;
        end

        check("ack_cycles", ack_cnt, exp_ack);
        check("cs_low_cycles", cs_low, exp_ack - 1);
        check("bit_count", nbits, 8 * n);
        check("mosi_data", got, data & mask);
        check("dc_level", {31'h0, dc_ok}, 32'd1);
        check("sclk_in_frame", {31'h0, sclk_ok}, 32'd1);
        check("done_cs_n", {31'h0, tft_cs_n}, 32'd1);
        check("done_sclk", {31'h0, tft_sclk}, 32'd0);
        if (!chain) bus.wi_in = 1'b0;
    endtask

    // Start a transfer, then pulse reset during T12 and expect a clean idle in T13.
    task automatic abort_xfer(input logic [1:0] mode, input logic [31:0] data);
        @(posedge clk); #1;
        bus.wi_in        = 1'b1;
        bus.addr_in      = mode_addr(mode);
        bus.writeData_in = data;
        @(negedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            bus.wi_in = 1'b0;
            if (c == 12) rst = 1'b1;
            @(negedge clk);
            if (c == 11) check("abort_busy_cs_n", {31'h0, tft_cs_n}, 32'd0);
            if (c == 12) check("abort_rst_ack", {31'h0, bus.ack_TFT}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_cs_n", {31'h0, tft_cs_n}, 32'd1);
        check("abort_sclk", {31'h0, tft_sclk}, 32'd0);
        check("abort_mosi", {31'h0, tft_mosi}, 32'd0);
        check("abort_dc", {31'h0, tft_dc}, 32'd0);
        check("abort_ack", {31'h0, bus.ack_TFT}, 32'd0);
    endtask

    logic [1:0]  rmode[17];
    logic [31:0] rdata[17];
    bit          rchain[17];

    initial begin
        rst              = 1'b1;
        bus.wi_in        = 1'b0;
        bus.addr_in      = '0;
        bus.writeData_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("por_cs_n", {31'h0, tft_cs_n}, 32'd1);
        check("por_sclk", {31'h0, tft_sclk}, 32'd0);
        check("por_ack", {31'h0, bus.ack_TFT}, 32'd0);

        // Command byte, then an RGB565 pixel (leaves dc high for the idle reset test).
        xfer(2'b00, 32'h0000_002A, 1'b0, 2'b00, '0, 0, 1'b0, 1'b0);
        xfer(2'b10, 32'h0000_F81F, 1'b0, 2'b00, '0, 0, 1'b0, 1'b0);

        // Reset for two cycles while idle, with a request asserted that must be ignored.
        @(posedge clk); #1;
        rst = 1'b1; bus.wi_in = 1'b1; bus.addr_in = mode_addr(2'b01); bus.writeData_in = 32'h55;
        @(negedge clk);
        check("rst_ack_low", {31'h0, bus.ack_TFT}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_cs_n", {31'h0, tft_cs_n}, 32'd1);
        check("rst_sclk", {31'h0, tft_sclk}, 32'd0);
        check("rst_mosi", {31'h0, tft_mosi}, 32'd0);
        check("rst_dc", {31'h0, tft_dc}, 32'd0);
        check("rst_ack", {31'h0, bus.ack_TFT}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.wi_in = 1'b0;

        // Word held through DONE with the next request; the follow-up must start back-to-back.
        xfer(2'b11, 32'hDEAD_BEEF, 1'b1, 2'b11, 32'h1234_5678, 0, 1'b0, 1'b0);
        xfer(2'b11, 32'h1234_5678, 1'b0, 2'b00, '0, 0, 1'b0, 1'b1);

        // Request held until T10, then data changed and wi dropped.
        xfer(2'b01, 32'h0000_0081, 1'b0, 2'b00, '0, 10, 1'b0, 1'b0);

        abort_xfer(2'b11, 32'hA5A5_5A5A);
        xfer(2'b10, 32'h0000_1357, 1'b0, 2'b00, '0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            rmode[i]  = 2'($urandom_range(0, 3));
            rdata[i]  = $urandom;
            rchain[i] = (i < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            xfer(rmode[i], rdata[i], rchain[i], rmode[i+1], rdata[i+1],
                 $urandom_range(0, 12), 1'($urandom_range(0, 1)), (i > 0) && rchain[i-1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
